pool2x2_window_sequencer: RTL and testbench
===========================================

Name: pool2x2_window_sequencer

Overview:
- Streaming controller that converts a raster-scan pixel stream (one Q2.30 word per beat) into non-overlapping 2x2 windows.
- Drives the combinational aad_pooling_2x2 datapath through x00/x01/x10/x11 and registers its pool_out into a valid/ready output stream.
- Buffers one even row internally, handles backpressure, and flags frame-length errors.

Parameters:
- WIDTH, 32, sample width (Q2.30 fixed point)
- FRAC_BITS, 30, fractional bits; passed through for consistency checks only
- IMG_W, 8, feature-map width in pixels; must be even and >= 2
- IMG_H, 8, feature-map height in rows; must be even and >= 2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts the pixel this cycle
- in_data  in  WIDTH  pixel, raster order, row-major
- in_last  in  1  asserted by source on the final pixel of a frame
- x00, x01, x10, x11  out  WIDTH each  window to the pooling datapath (top-left, top-right, bottom-left, bottom-right)
- pool_in  in  WIDTH  pool_out returned from the pooling datapath
- out_valid  out  1  pooled result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  pooled result
- out_last  out  1  marks the final result of a frame ((IMG_W/2)*(IMG_H/2)-th)
- frame_err  out  1  sticky; in_last position mismatched the frame geometry

Behaviour:
- Reset (async, active-high): all outputs 0; in_ready=0 while rst is high; col=0, row=0; state=EVEN_ROW; window and line-buffer valid flags cleared. Line-buffer contents are don't-care.
- Accept occurs when in_valid && in_ready. The col counter wraps at IMG_W-1. The row counter advances on col wrap and wraps at IMG_H-1 back to 0 (frame boundary).
- State EVEN_ROW (row even): each accepted pixel is written to linebuf[col]. On the col wrap, the state goes to ODD_ROW.
- State ODD_ROW: an accept at even col stores the pixel in hold_reg. An accept at odd col loads the window register:
  - x00 = linebuf[col-1], x01 = linebuf[col]
  - x10 = hold_reg, x11 = in_data
  - win_valid is set on this load.
  - On the col wrap, the state goes to EVEN_ROW.
- x00..x11 are driven directly from the window register and are stable while win_valid=1.
- Result stage: when win_valid && (!out_valid || out_ready), then on that edge out_data <= pool_in, out_valid <= 1, out_last <= (window is the last of the frame), and win_valid clears unless a new window loads on the same edge.
- Latency: accept of the x11 beat at edge N; window valid after N; out_valid asserted after edge N+1.
- in_ready = !rst && !(win_valid && out_valid && !out_ready). In all other states the block accepts one pixel per cycle with no bubbles, giving sustained 1 pixel/cycle and 1 result per 4 pixels.
- out_valid clears on out_ready when no new result is loaded. Simultaneous load and drain is allowed.
- in_last check: if in_last=1 on an accepted beat that is not (row=IMG_H-1, col=IMG_W-1), or in_last=0 on that final beat, frame_err is set (sticky until rst). Counters are not resynchronised; geometry is authoritative.
- Reset mid-frame: partial windows and buffered rows are discarded and no result is emitted. The next accepted pixel is treated as (0,0).

Optional Feature:
- Macro POOL_STATS_EN.
- When defined, adds outputs stat_frames (16b, count of completed out_last handshakes) and stat_stalls (16b, cycles with in_valid && !in_ready). Both saturate at 0xFFFF and clear on rst.
- When undefined, these ports and counters do not exist and the logic is otherwise identical.

Decomposition:
- Package pool_pkg:
  - WIDTH/FRAC_BITS defaults
  - state enum {EVEN_ROW, ODD_ROW}
  - Q2.30 constants ONE=32'h4000_0000, HALF=32'h2000_0000
- Sub-module pool_line_buffer: IMG_W x WIDTH storage, one write port, two combinational read ports (col-1, col).
- The top level holds the FSM, counters, window and result registers.

Test Plan:
- Reset then a 4x4 frame (IMG_W=IMG_H=4) of pixels p(r,c) = (r*4+c)*2^-4 in Q2.30. Required response:
  - first window x00=0x0000_0000, x01=0x0400_0000, x10=0x1000_0000, x11=0x1400_0000
  - 4 results emitted
  - out_last only on the 4th
  - out_valid exactly 2 edges after each odd-row odd-col accept
- Same frame with out_ready held 0 after the first result. Required response: in_ready drops once win_valid && out_valid; no window is lost; releasing out_ready drains all 4 results in order.
- Back-to-back frames with in_valid constant 1 and out_ready=1. Required response: 8 results, zero stall cycles, out_last on results 4 and 8.
- in_last asserted at pixel (1,1) of a 4x4 frame. Required response: frame_err=1 and it remains 1 through the rest of the frame; results are still produced per geometry.
- Assert rst for one cycle after 6 pixels of a frame. Required response: no output for the partial frame; the next full frame yields correct windows starting at (0,0); frame_err=0.
- With POOL_STATS_EN defined, run the second scenario. Required response: stat_stalls equals the number of cycles with in_valid && !in_ready; stat_frames=1 after drain.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 pooling window sequencer.
package pool_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int FRAC_BITS_DEF = 30;

  // Q2.30 reference constants.
  localparam logic [31:0] ONE  = 32'h4000_0000;
  localparam logic [31:0] HALF = 32'h2000_0000;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } state_t;

  // Index width for a counter over n positions (never narrower than 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row pixel store: single write port, two combinational read ports.
module pool_line_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are don't-care after reset, so the store carries no reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/pool2x2_window_sequencer.sv
// Raster-stream to non-overlapping 2x2 window sequencer with registered
// valid/ready result stage and frame-length checking.
// Optional build macro: POOL_STATS_EN adds stat_frames / stat_stalls counters.
module pool2x2_window_sequencer
  import pool_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] x00,
  output logic [WIDTH-1:0] x01,
  output logic [WIDTH-1:0] x10,
  output logic [WIDTH-1:0] x11,
  input  logic [WIDTH-1:0] pool_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             frame_err
`ifdef POOL_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_stalls
`endif
);

  localparam int CW = idx_w(IMG_W);
  localparam int RW = idx_w(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2 ||
      FRAC_BITS >= WIDTH) begin : g_cfg_err
    $error("pool2x2_window_sequencer: geometry must be even and >= 2, FRAC_BITS < WIDTH");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] x00_q, x00_d, x01_q, x01_d, x10_q, x10_d, x11_q, x11_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             frame_err_q, frame_err_d;

  logic             accept, col_wrap, final_px, res_fire, win_load, lb_we;
  logic [WIDTH-1:0] lb_left, lb_right;

  // Stall only when a finished window is waiting behind a blocked result.
  assign in_ready = !rst && !(win_valid_q && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign col_wrap = (col_q == COL_MAX);
  assign final_px = col_wrap && (row_q == ROW_MAX);
  assign res_fire = win_valid_q && (!out_valid_q || out_ready);
  assign win_load = accept && (state_q == ODD_ROW) && col_q[0];
  assign lb_we    = accept && (state_q == EVEN_ROW);

  pool_line_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_linebuf (
    .clk       (clk),
    .we_i      (lb_we),
    .waddr_i   (col_q),
    .wdata_i   (in_data),
    .raddr_a_i (col_q - CW'(1)),
    .rdata_a_o (lb_left),
    .raddr_b_i (col_q),
    .rdata_b_o (lb_right)
  );

  // Row-parity FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EVEN_ROW;
    else     state_q <= state_d;
  end

  // Row-parity FSM: flips at every accepted end-of-row pixel.
  always_comb begin
    state_d = state_q;
    if (accept && col_wrap) begin
      case (state_q)
        EVEN_ROW: state_d = ODD_ROW;
        ODD_ROW:  state_d = EVEN_ROW;
        default:  state_d = EVEN_ROW;
      endcase
    end
  end

  // Counters, window capture, result stage and frame check next-state.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    x00_d       = x00_q;
    x01_d       = x01_q;
    x10_d       = x10_q;
    x11_d       = x11_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_err_d = frame_err_q;

    if (accept) begin
      col_d = col_wrap ? '0 : col_q + CW'(1);
      if (col_wrap) row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      if (state_q == ODD_ROW && !col_q[0]) hold_d = in_data;
      if (in_last != final_px) frame_err_d = 1'b1;
    end

    if (res_fire) begin
      out_data_d  = pool_in;
      out_valid_d = 1'b1;
      out_last_d  = win_last_q;
      win_valid_d = 1'b0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (win_load) begin
      x00_d       = lb_left;
      x01_d       = lb_right;
      x10_d       = hold_q;
      x11_d       = in_data;
      win_valid_d = 1'b1;
      win_last_d  = final_px;
    end
  end

  // Control and output registers; everything visible resets to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      x00_q       <= '0;
      x01_q       <= '0;
      x10_q       <= '0;
      x11_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      x00_q       <= x00_d;
      x01_q       <= x01_d;
      x10_q       <= x10_d;
      x11_q       <= x11_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Even-column pixel of an odd row, waiting for its right-hand neighbour.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign x00       = x00_q;
  assign x01       = x01_q;
  assign x10       = x10_q;
  assign x11       = x11_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;

`ifdef POOL_STATS_EN
  logic [15:0] stat_frames_q, stat_stalls_q;

  // Saturating counters: completed frames and source-side stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (out_valid_q && out_ready && out_last_q && stat_frames_q != 16'hFFFF)
        stat_frames_q <= stat_frames_q + 16'd1;
      if (in_valid && !in_ready && stat_stalls_q != 16'hFFFF)
        stat_stalls_q <= stat_stalls_q + 16'd1;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_pool2x2_window_sequencer.sv
// Directed bench for pool2x2_window_sequencer on a 4x4 frame.
// The pooling datapath is stood in for by a 4-input average.
module tb_pool2x2_window_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [31:0] x00, x01, x10, x11;
  logic [31:0] pool_in;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        frame_err;
`ifdef POOL_STATS_EN
  logic [15:0] stat_frames, stat_stalls;
`endif

  pool2x2_window_sequencer #(
    .WIDTH(32), .FRAC_BITS(30), .IMG_W(4), .IMG_H(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .x00(x00), .x01(x01), .x10(x10), .x11(x11),
    .pool_in(pool_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_err(frame_err)
`ifdef POOL_STATS_EN
    , .stat_frames(stat_frames), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in pooling datapath: average of the four window samples.
  logic [33:0] psum;
  assign psum    = 34'(x00) + 34'(x01) + 34'(x10) + 34'(x11);
  assign pool_in = psum[33:2];

  // Hand-computed averages of windows {0,1,4,5},{2,3,6,7},{8,9,12,13},{10,11,14,15} * 2^-4.
  logic [31:0] EXP [4] = '{32'h0A00_0000, 32'h1200_0000, 32'h2A00_0000, 32'h3200_0000};

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int n_stall = 0;
  logic tb_x11 = 1'b0;
  logic [31:0] res_data [$];
  logic        res_last [$];
  int          res_cyc  [$];
  int          acc_cyc  [$];

  // Observer: samples 3 time units after each falling edge, well clear of the rising edge.
  always @(negedge clk) begin
    #3;
    cyc++;
    if (rst) n_stall = 0;
    else if (in_valid && !in_ready) n_stall++;
    if (in_valid && in_ready && tb_x11) acc_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      res_data.push_back(out_data);
      res_last.push_back(out_last);
      res_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    res_data.delete();
    res_last.delete();
    res_cyc.delete();
    acc_cyc.delete();
  endtask

  // Present pixel idx of the 4x4 frame and return at the falling edge after it is taken.
  task automatic push_px(input int idx, input int err_at);
    int n;
    int r;
    int c;
    r = idx / 4;
    c = idx % 4;
    in_valid = 1'b1;
    in_data  = 32'(idx) << 26;
    in_last  = (idx == 15) || (idx == err_at);
    tb_x11   = ((r % 2) == 1) && ((c % 2) == 1);
    n = 0;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    ncmp++;
    assert (n < 200) else begin
      nfail++;
      $error("FAIL push_timeout: pixel %0d not accepted within %0d cycles", idx, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tb_x11   = 1'b0;
  endtask

  task automatic push_range(input int lo, input int hi, input int err_at);
    for (int i = lo; i <= hi; i++) push_px(i, err_at);
  endtask

  task automatic wait_results(input int want, input string tag);
    int n;
    n = 0;
    while (res_data.size() < want && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_count"}, 32'(res_data.size()), 32'(want));
  endtask

  task automatic check_results(input string tag, input int base, input int nres);
    for (int k = 0; k < nres; k++) begin
      if (res_data.size() > base + k) begin
        check($sformatf("%s_data%0d", tag, base + k), res_data[base + k], EXP[k % 4]);
        check1($sformatf("%s_last%0d", tag, base + k), res_last[base + k], (k % 4) == 3);
      end
    end
  endtask

  task automatic check_first_window(input string tag);
    check({tag, "_x00"}, x00, 32'h0000_0000);
    check({tag, "_x01"}, x01, 32'h0400_0000);
    check({tag, "_x10"}, x10, 32'h1000_0000);
    check({tag, "_x11"}, x11, 32'h1400_0000);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int stall_base;

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check1("rst_frame_err", frame_err, 1'b0);
    check("rst_x00", x00, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: one frame, free-flowing output
    clear_log();
    push_range(0, 5, -1);
    check_first_window("s1");
    push_range(6, 15, -1);
    wait_results(4, "s1");
    check_results("s1", 0, 4);
    for (int k = 0; k < 4; k++)
      if (res_cyc.size() > k && acc_cyc.size() > k)
        check($sformatf("s1_latency%0d", k), 32'(res_cyc[k] - acc_cyc[k]), 32'd2);
    check1("s1_frame_err", frame_err, 1'b0);

    // Scenario 2: output blocked after the first result
    pulse_reset();
    clear_log();
    out_ready = 1'b1;
    fork
      push_range(0, 15, -1);
      begin : ctl
        int n;
        n = 0;
        while (res_data.size() < 1 && n < 200) begin
          @(negedge clk);
          n++;
        end
        out_ready = 1'b0;
        n = 0;
        #1;
        while (in_ready && n < 50) begin
          @(negedge clk);
          #1;
          n++;
        end
        check1("s2_stall_in_ready", in_ready, 1'b0);
        check1("s2_stall_out_valid", out_valid, 1'b1);
        check("s2_stall_out_data", out_data, EXP[1]);
        repeat (10) @(negedge clk);
        #1;
        check1("s2_still_stalled", in_ready, 1'b0);
        check("s2_held_count", 32'(res_data.size()), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_results(4, "s2");
    check_results("s2", 0, 4);
`ifdef POOL_STATS_EN
    check("s2_stat_stalls", 32'(stat_stalls), 32'(n_stall));
    check("s2_stat_frames", 32'(stat_frames), 32'd1);
`endif

    // Scenario 3: two frames back to back, no bubbles
    clear_log();
    stall_base = n_stall;
    push_range(0, 15, -1);
    push_range(0, 15, -1);
    wait_results(8, "s3");
    check_results("s3", 0, 8);
    check("s3_stalls", 32'(n_stall - stall_base), 32'd0);

    // Scenario 4: early in_last at (1,1)
    clear_log();
    push_range(0, 5, 5);
    check1("s4_err_set", frame_err, 1'b1);
    push_range(6, 15, 5);
    wait_results(4, "s4");
    check_results("s4", 0, 4);
    check1("s4_err_sticky", frame_err, 1'b1);

    // Scenario 5: reset after 6 pixels, then a clean frame
    clear_log();
    push_range(0, 5, -1);
    pulse_reset();
    repeat (5) @(negedge clk);
    check("s5_partial_count", 32'(res_data.size()), 32'd0);
    check1("s5_out_valid", out_valid, 1'b0);
    check1("s5_err_cleared", frame_err, 1'b0);
    push_range(0, 5, -1);
    check_first_window("s5");
    push_range(6, 15, -1);
    wait_results(4, "s5");
    check_results("s5", 0, 4);
    check1("s5_frame_err", frame_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule
